// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-side sequencer: FSM states,
// R-type field positions and function codes.
package mips_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      EXEC    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int RS_MSB   = 25;
   localparam int RS_LSB   = 21;
   localparam int RT_MSB   = 20;
   localparam int RT_LSB   = 16;
   localparam int FUNC_MSB = 5;
   localparam int FUNC_LSB = 0;

   localparam logic [5:0] FUNC_ADD = 6'b100000;

endpackage

// File: rtl/issue_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with count-based full/empty and a
// combinational head read (rd_data always shows the oldest entry).
module issue_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // A push while full is dropped, even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_issue_seq.sv
// Drains buffered R-type words onto the MIPS datapath, holds each for an execute
// window and captures top.exit. Optional res_sum port under RESULT_CHECKSUM_EN.
module instr_issue_seq
   import mips_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int EXEC_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_wr,
   input  logic [31:0] instr_data,
   output logic        instr_full,
   input  logic        start,
   output logic        busy,
   output logic [5:0]  opc,
   output logic [5:0]  func,
   output logic [4:0]  Number1,
   output logic [4:0]  Number2,
   input  logic [31:0] exit_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [7:0]  res_index,
   output logic        done,
`ifdef RESULT_CHECKSUM_EN
   output logic [31:0] res_sum,
`endif
   output state_t      dbg_state
);

   localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          exec_last;
   logic          fifo_pop;
   logic          fifo_empty;
   logic [31:0]   head;
   logic          unused_head_bits;

   issue_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (instr_wr),
      .pop     (fifo_pop),
      .wr_data (instr_data),
      .rd_data (head),
      .full    (instr_full),
      .empty   (fifo_empty)
   );

   assign unused_head_bits = ^head[RT_LSB-1:FUNC_MSB+1];
   assign exec_last = (cnt == CW'(EXEC_CYCLES - 1));
   assign fifo_pop  = (state == ISSUE) && !fifo_empty;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

   // Result handshake: res_valid rises with res_data/res_index and all three stay
   // stable until the cycle where res_valid && res_ready; that edge retires it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   state_nxt = fifo_empty ? DONE : EXEC;
         EXEC:    if (exec_last) state_nxt = CAPTURE;
         CAPTURE: if (res_ready) state_nxt = ISSUE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         opc       <= '0;
         func      <= '0;
         Number1   <= '0;
         Number2   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_index <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ISSUE: begin
               if (!fifo_empty) begin
                  opc     <= head[OPC_MSB:OPC_LSB];
                  func    <= head[FUNC_MSB:FUNC_LSB];
                  Number1 <= head[RS_MSB:RS_LSB];
                  Number2 <= head[RT_MSB:RT_LSB];
                  cnt     <= '0;
               end
            end
            EXEC: begin
               cnt <= cnt + CW'(1);
               if (exec_last) begin
                  res_valid <= 1'b1;
                  res_data  <= exit_in;
               end
            end
            CAPTURE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_index <= res_index + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RESULT_CHECKSUM_EN
   always_ff @(posedge clock) begin
      if (reset || (state == IDLE && start)) res_sum <= '0;
      else if (res_valid && res_ready)       res_sum <= res_sum ^ res_data;
   end
`endif

endmodule

// File: tb/tb_instr_issue_seq.sv
// Randomized bench for instr_issue_seq: an instruction queue model plus
// cycle-count timing rules predict fields, results, indices and done.
module tb_instr_issue_seq;
   import mips_pkg::*;

   localparam int DEPTH = 8;
   localparam int EC    = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_wr;
   logic [31:0] instr_data;
   logic        instr_full;
   logic        start;
   logic        busy;
   logic [5:0]  opc;
   logic [5:0]  func;
   logic [4:0]  Number1;
   logic [4:0]  Number2;
   logic [31:0] exit_in;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [7:0]  res_index;
   logic        done;
`ifdef RESULT_CHECKSUM_EN
   logic [31:0] res_sum;
`endif
   state_t      dbg_state;

   instr_issue_seq #(.DEPTH(DEPTH), .EXEC_CYCLES(EC)) dut (
      .clock      (clock),
      .reset      (reset),
      .instr_wr   (instr_wr),
      .instr_data (instr_data),
      .instr_full (instr_full),
      .start      (start),
      .busy       (busy),
      .opc        (opc),
      .func       (func),
      .Number1    (Number1),
      .Number2    (Number2),
      .exit_in    (exit_in),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_index  (res_index),
      .done       (done),
`ifdef RESULT_CHECKSUM_EN
      .res_sum    (res_sum),
`endif
      .dbg_state  (dbg_state)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];        // model of FIFO contents, oldest first
   logic [31:0] exit_plan_q[$];  // forced exit_in values for capture edges
   logic [7:0]  model_idx;
   logic [31:0] model_sum;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_opc"}, opc, 0);
      check({tag, "_func"}, func, 0);
      check({tag, "_n1"}, Number1, 0);
      check({tag, "_n2"}, Number2, 0);
      check({tag, "_valid"}, res_valid, 0);
      check({tag, "_data"}, res_data, 0);
      check({tag, "_index"}, res_index, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_full"}, instr_full, 0);
      check({tag, "_state"}, dbg_state, IDLE);
`ifdef RESULT_CHECKSUM_EN
      check({tag, "_sum"}, res_sum, 0);
`endif
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      instr_wr = 1'b0; instr_data = '0; start = 1'b0; res_ready = 1'b0; exit_in = '0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      model_idx = '0;
      model_sum = '0;
   endtask

   task automatic push_word(input logic [31:0] w);
      instr_wr = 1'b1;
      instr_data = w;
      check("full_before_push", instr_full, (exp_q.size() == DEPTH));
      tick();
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      instr_wr = 1'b0;
   endtask

   // One start..done run; each result is held for stall cycles before acceptance
   // (stall 0 keeps res_ready high for the whole run).
   task automatic run_program(input int stall, input bit mid_push);
      int          pushes_left;
      logic [31:0] w;
      logic [31:0] v;
      pushes_left = mid_push ? 2 : 0;
      res_ready = (stall == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      model_sum = '0;
      check("busy_after_start", busy, 1);
      for (int n = 0; n <= 2 * DEPTH + 4; n++) begin
         tick();
         if (exp_q.size() == 0) begin
            check("done_pulse", done, 1);
            check("busy_in_done", busy, 1);
            check("no_valid_in_done", res_valid, 0);
            tick();
            check("done_cleared", done, 0);
            check("busy_low_after_done", busy, 0);
            break;
         end
         w = exp_q.pop_front();
         check("opc", opc, w[31:26]);
         check("func", func, w[5:0]);
         check("number1", Number1, w[25:21]);
         check("number2", Number2, w[20:16]);
         check("valid_low_at_issue", res_valid, 0);
         v = '0;
         for (int c = 0; c < EC; c++) begin
            v = $urandom();
            if (c == EC - 1 && exit_plan_q.size() > 0) v = exit_plan_q.pop_front();
            exit_in = v;
            if (c < EC - 1 && pushes_left > 0 && $urandom_range(0, 1) == 1) begin
               instr_wr = 1'b1;
               instr_data = $urandom();
               if (exp_q.size() < DEPTH) exp_q.push_back(instr_data);
               pushes_left--;
            end
            if (c == 1) start = 1'b1;
            tick();
            instr_wr = 1'b0;
            start = 1'b0;
            if (c < EC - 1) check("valid_low_in_exec", res_valid, 0);
         end
         check("valid_at_capture", res_valid, 1);
         check("res_data", res_data, v);
         check("res_index", res_index, model_idx);
         check("busy_in_capture", busy, 1);
         for (int s = 0; s < stall; s++) begin
            exit_in = $urandom();
            tick();
            check("stall_valid", res_valid, 1);
            check("stall_data", res_data, v);
            check("stall_index", res_index, model_idx);
            check("stall_opc", opc, w[31:26]);
            check("stall_n2", Number2, w[20:16]);
         end
         res_ready = 1'b1;
         tick();
         res_ready = (stall == 0);
         model_idx = model_idx + 8'd1;
         model_sum = model_sum ^ v;
         check("valid_low_after_accept", res_valid, 0);
`ifdef RESULT_CHECKSUM_EN
         check("res_sum", res_sum, model_sum);
`endif
      end
      res_ready = 1'b0;
   endtask

   initial begin
      reset_dut();
      check_all_zero("reset");

      // Single add rs=0 rt=1.
      push_word(32'h0001_1020);
      run_program(0, 1'b0);
      check("fields_hold_opc", opc, 0);
      check("fields_hold_func", func, 32'h20);
      check("fields_hold_n2", Number2, 1);

      // Three back-to-back instructions from a fresh index.
      reset_dut();
      for (int i = 0; i < 3; i++) push_word($urandom());
      run_program(0, 1'b0);
      check("index_after_three", res_index, 3);

      // Overfill: the DEPTH+1-th word is dropped.
      reset_dut();
      for (int i = 0; i < DEPTH + 1; i++) push_word($urandom());
      check("full_after_overfill", instr_full, 1);
      check("model_depth", exp_q.size(), DEPTH);
      run_program($urandom_range(0, 2), 1'b0);
      check("index_after_full_run", res_index, model_idx);

      // Long back-pressure with pushes arriving mid-run.
      push_word($urandom());
      push_word($urandom());
      run_program(10, 1'b1);

      // Empty start; start held into ISSUE must not retrigger.
      start = 1'b1;
      tick();
      check("empty_busy", busy, 1);
      tick();
      start = 1'b0;
      check("empty_done", done, 1);
      check("empty_no_valid", res_valid, 0);
      tick();
      check("empty_idle", busy, 0);
      tick();
      check("empty_stays_idle", busy, 0);
      check("empty_no_done", done, 0);

      // Randomized runs.
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) push_word($urandom());
         run_program($urandom_range(0, 3), 1'b1);
      end

      // Reset in the middle of EXEC with a full FIFO.
      reset_dut();
      for (int i = 0; i < DEPTH; i++) push_word($urandom());
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      instr_wr = 1'b1;
      instr_data = $urandom();
      tick();
      instr_wr = 1'b0;
      check("full_before_reset", instr_full, 1);
      check("exec_before_reset", dbg_state, EXEC);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("mid_reset");
      exp_q.delete();
      model_idx = '0;

`ifdef RESULT_CHECKSUM_EN
      reset_dut();
      push_word($urandom());
      push_word($urandom());
      exit_plan_q.push_back(32'h5);
      exit_plan_q.push_back(32'h3);
      run_program(0, 1'b0);
      check("checksum_5_3", res_sum, 32'h6);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
